// File: rtl/status_register.sv
// Processor status register (P) for a 6502-style core.
// Holds the C, Z, I, D, V and N flags. Each flag is loaded from the internal
// bus, the ALU or instruction bit 5 under per-flag strobes. The register also
// has the Set Overflow pin synchronizer, the delayed interrupt mask and the
// p_db image used for PHP and interrupt pushes.
module status_register (
  input  logic       clk,
  input  logic       rst,
  input  logic       acr,
  input  logic       avr,
  input  logic [7:0] db,
  input  logic       ir5,
  input  logic       db0_c,
  input  logic       acr_c,
  input  logic       ir5_c,
  input  logic       db1_z,
  input  logic       dbz_z,
  input  logic       db2_i,
  input  logic       ir5_i,
  input  logic       db3_d,
  input  logic       ir5_d,
  input  logic       db6_v,
  input  logic       avr_v,
  input  logic       clr_v,
  input  logic       db7_n,
  input  logic       so_n,
  input  logic       brk_push,
  output logic [7:0] p_db,
  output logic       decimal_en,
  output logic       irq_mask
);

  logic c_q, c_d;
  logic z_q, z_d;
  logic i_q, i_d;
  logic d_q, d_d;
  logic v_q, v_d;
  logic n_q, n_d;
  logic irq_mask_q;
  logic so_s1_q, so_s2_q, so_hist_q;
  logic so_set;

  // A synchronized high-to-low transition on so_n raises so_set for one clock.
  assign so_set = so_hist_q & ~so_s2_q;

  // Next-state selection for each flag, in the documented source priority.
  always_comb begin
    // NOTE: every output of this block gets a default first, so a path that
    // assigns nothing leaves the flag unchanged instead of inferring a latch.
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    d_d = d_q;
    v_d = v_q;
    n_d = n_q;

    if (db0_c)      c_d = db[0];
    else if (acr_c) c_d = acr;
    else if (ir5_c) c_d = ir5;

    // Zero test uses the live bus value in the strobe cycle.
    if (db1_z)      z_d = db[1];
    else if (dbz_z) z_d = (db == 8'h00);

    if (db2_i)      i_d = db[2];
    else if (ir5_i) i_d = ir5;

    if (db3_d)      d_d = db[3];
    else if (ir5_d) d_d = ir5;

    if (db7_n)      n_d = db[7];

    if (so_set)      v_d = 1'b1;
    else if (db6_v)  v_d = db[6];
    else if (avr_v)  v_d = avr;
    else if (clr_v)  v_d = 1'b0;
  end

  // Flag registers and the interrupt-mask delay. Reset takes priority over every strobe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples values from before the edge, regardless of statement order.
    if (rst) begin
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      i_q        <= 1'b1;
      d_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      irq_mask_q <= 1'b1;
    end else begin
      c_q        <= c_d;
      z_q        <= z_d;
      i_q        <= i_d;
      d_q        <= d_d;
      v_q        <= v_d;
      n_q        <= n_d;
      irq_mask_q <= i_q;
    end
  end

  // so_n synchronizer and edge history. Resetting to 1 means the reset state
  // itself looks like an idle-high pin, so it cannot produce an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      so_s1_q   <= 1'b1;
      so_s2_q   <= 1'b1;
      so_hist_q <= 1'b1;
    end else begin
      so_s1_q   <= so_n;
      so_s2_q   <= so_s1_q;
      so_hist_q <= so_s2_q;
    end
  end

  assign p_db       = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign decimal_en = d_q;
  assign irq_mask   = irq_mask_q;

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: directed scenarios followed by
// randomized traffic. Every cycle is compared against a flag-level reference model.
module tb_status_register;

  logic       clk = 1'b0;
  logic       rst, acr, avr, ir5, so_n, brk_push;
  logic [7:0] db;
  logic       db0_c, acr_c, ir5_c, db1_z, dbz_z, db2_i, ir5_i;
  logic       db3_d, ir5_d, db6_v, avr_v, clr_v, db7_n;
  logic [7:0] p_db;
  logic       decimal_en, irq_mask;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural flags plus a record of pin and reset
  // history over the last three clock edges.
  bit m_c, m_z, m_i, m_d, m_v, m_n, m_irq;
  bit rh1 = 1'b1, rh2 = 1'b1, rh3 = 1'b1;
  bit sh1 = 1'b1, sh2 = 1'b1, sh3 = 1'b1;

  status_register dut (
    .clk(clk), .rst(rst), .acr(acr), .avr(avr), .db(db), .ir5(ir5),
    .db0_c(db0_c), .acr_c(acr_c), .ir5_c(ir5_c), .db1_z(db1_z), .dbz_z(dbz_z),
    .db2_i(db2_i), .ir5_i(ir5_i), .db3_d(db3_d), .ir5_d(ir5_d), .db6_v(db6_v),
    .avr_v(avr_v), .clr_v(clr_v), .db7_n(db7_n), .so_n(so_n),
    .brk_push(brk_push), .p_db(p_db), .decimal_en(decimal_en), .irq_mask(irq_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_strobes();
    db0_c = 0; acr_c = 0; ir5_c = 0; db1_z = 0; dbz_z = 0; db2_i = 0; ir5_i = 0;
    db3_d = 0; ir5_d = 0; db6_v = 0; avr_v = 0; clr_v = 0; db7_n = 0;
  endtask

  task automatic all_strobes();
    db0_c = 1; acr_c = 1; ir5_c = 1; db1_z = 1; dbz_z = 1; db2_i = 1; ir5_i = 1;
    db3_d = 1; ir5_d = 1; db6_v = 1; avr_v = 1; clr_v = 1; db7_n = 1;
  endtask

  // Apply one clock edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    bit so_set;
    // The pin was seen low two edges ago after being high (or in reset) three
    // edges ago, and the synchronizer has been out of reset since then.
    so_set = !rh1 && !rh2 && !sh2 && (rh3 || sh3);
    if (rst) begin
      m_c = 0; m_z = 0; m_i = 1; m_d = 0; m_v = 0; m_n = 0; m_irq = 1;
    end else begin
      m_irq = m_i;
      if (db0_c) m_c = db[0]; else if (acr_c) m_c = acr; else if (ir5_c) m_c = ir5;
      if (db1_z) m_z = db[1]; else if (dbz_z) m_z = (db == 8'h00);
      if (db2_i) m_i = db[2]; else if (ir5_i) m_i = ir5;
      if (db3_d) m_d = db[3]; else if (ir5_d) m_d = ir5;
      if (db7_n) m_n = db[7];
      if (so_set) m_v = 1; else if (db6_v) m_v = db[6];
      else if (avr_v) m_v = avr; else if (clr_v) m_v = 0;
    end
    rh3 = rh2; rh2 = rh1; rh1 = rst;
    sh3 = sh2; sh2 = sh1; sh1 = so_n;
  endtask

  function automatic logic [7:0] model_p();
    return {m_n, m_v, 1'b1, brk_push, m_d, m_i, m_z, m_c};
  endfunction

  // One clock: update the model at the edge, then compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("p_db", p_db, model_p());
    check("decimal_en", {7'd0, decimal_en}, {7'd0, m_d});
    check("irq_mask", {7'd0, irq_mask}, {7'd0, m_irq});
  endtask

  initial begin
    rst = 1; acr = 0; avr = 0; ir5 = 0; so_n = 1; brk_push = 0; db = 8'h00;
    clear_strobes();
    m_c = 0; m_z = 0; m_i = 1; m_d = 0; m_v = 0; m_n = 0; m_irq = 1;
    #1;
    repeat (3) tick();
    rst = 0;
    tick();

    // Reset image with both push variants.
    check("reset_p_brk0", p_db, 8'h24);
    check("reset_irq", {7'd0, irq_mask}, 8'h01);
    brk_push = 1; #1;
    check("reset_p_brk1", p_db, 8'h34);
    brk_push = 0;

    // Zero test on a zero bus together with an ALU carry load.
    db = 8'h00; dbz_z = 1; acr = 1; acr_c = 1;
    tick();
    clear_strobes();
    check("zc_load", p_db, 8'h27);

    // Load every flag from the bus in one cycle. I goes to 0, and the mask follows one clock later.
    db = 8'hC3; db0_c = 1; db1_z = 1; db2_i = 1; db3_d = 1; db6_v = 1; db7_n = 1;
    tick();
    clear_strobes();
    check("irq_lag_hold", {7'd0, irq_mask}, 8'h01);
    tick();
    check("irq_lag_drop", {7'd0, irq_mask}, 8'h00);

    // SED / CLD via ir5.
    ir5 = 1; ir5_d = 1; tick();
    check("sed", {7'd0, decimal_en}, 8'h01);
    ir5 = 0; tick();
    check("cld", {7'd0, decimal_en}, 8'h00);
    clear_strobes();

    // db0_c takes priority over acr_c.
    db = 8'h00; acr = 1; db0_c = 1; acr_c = 1; tick();
    check("c_priority", {7'd0, p_db[0]}, 8'h00);
    clear_strobes();

    // SO edge against a simultaneous avr load of 0. SO wins.
    clr_v = 1; tick(); clear_strobes();
    so_n = 0; tick();            // edge k
    tick();                      // edge k+1
    avr = 0; avr_v = 1; tick();  // edge k+2
    avr_v = 0;
    check("so_wins", {7'd0, p_db[6]}, 8'h01);
    clr_v = 1; tick(); clr_v = 0;
    repeat (10) tick();
    check("so_single", {7'd0, p_db[6]}, 8'h00);
    so_n = 1; repeat (3) tick();

    // An SO pulse that falls and is fully synchronized during reset is lost.
    rst = 1; tick();
    so_n = 0; repeat (3) tick();
    so_n = 1; tick();
    rst = 0; repeat (5) tick();
    check("so_in_reset", {7'd0, p_db[6]}, 8'h00);

    // Mid-sequence reset with every strobe asserted.
    db = 8'hFF; acr = 1; avr = 1; ir5 = 1; all_strobes(); tick();
    rst = 1; tick();
    check("rst_override_p", p_db, 8'h24);
    check("rst_override_irq", {7'd0, irq_mask}, 8'h01);
    rst = 0; clear_strobes(); tick();

    // Randomized traffic with occasional resets and SO activity.
    for (int n = 0; n < 3000; n++) begin
      db = 8'($urandom); acr = 1'($urandom); avr = 1'($urandom);
      ir5 = 1'($urandom); brk_push = 1'($urandom);
      db0_c = ($urandom_range(0, 3) == 0); acr_c = ($urandom_range(0, 3) == 0);
      ir5_c = ($urandom_range(0, 3) == 0); db1_z = ($urandom_range(0, 3) == 0);
      dbz_z = ($urandom_range(0, 3) == 0); db2_i = ($urandom_range(0, 3) == 0);
      ir5_i = ($urandom_range(0, 3) == 0); db3_d = ($urandom_range(0, 3) == 0);
      ir5_d = ($urandom_range(0, 3) == 0); db6_v = ($urandom_range(0, 5) == 0);
      avr_v = ($urandom_range(0, 5) == 0); clr_v = ($urandom_range(0, 5) == 0);
      db7_n = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) db = 8'h00;
      if ($urandom_range(0, 6) == 0) so_n = ~so_n;
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
